// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: turns one raw push-button and a switch bank into an
// ordered F -> A -> B write sequence for the ALU register decode.
// The button is synchronised and debounced, and each accepted press gives
// at most one write strobe. Illegal op codes are rejected with op_err, and
// completed operand sets are counted.
module alu_input_sequencer #(
    parameter int WIDTH     = 6,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic [WIDTH-1:0] sw,
    output logic             en,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] x,
    output logic [1:0]       stage,
    output logic             ready,
    output logic             op_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int DBC_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_F = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic             r_btn_db_d;
    logic [DBC_W-1:0] r_db_cnt;
    state_t           r_state;
    logic             r_en;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_x;
    logic             r_op_err;
    logic [CNT_W-1:0] r_op_count;

    logic             w_press;
    state_t           w_state_nxt;
    logic             w_en_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_err_nxt;
    logic             w_cnt_inc;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the level follows btn_s only after DB_CYCLES consecutive mismatching edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_sync2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBC_W'(1);
            end
        end
    end

    assign w_press = r_btn_db & ~r_btn_db_d;

    // Load-stage state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_F;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-strobe decode; only a press moves the sequence on
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_sel_nxt   = 2'b00;
        w_err_nxt   = 1'b0;
        w_cnt_inc   = 1'b0;
        if (w_press) begin
            unique case (r_state)
                LOAD_F: begin
                    if (sw[2:0] <= 3'b101) begin
                        w_en_nxt    = 1'b1;
                        w_sel_nxt   = 2'b00;
                        w_state_nxt = LOAD_A;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                LOAD_A: begin
                    w_en_nxt    = 1'b1;
                    w_sel_nxt   = 2'b01;
                    w_state_nxt = LOAD_B;
                end
                LOAD_B: begin
                    w_en_nxt    = 1'b1;
                    w_sel_nxt   = 2'b10;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = DONE;
                end
                DONE: begin
                    w_state_nxt = LOAD_F;
                end
                default: begin
                    w_state_nxt = LOAD_F;
                end
            endcase
        end
    end

    // Registered strobes; sel and x hold their last written values between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_sel      <= 2'b00;
            r_x        <= '0;
            r_op_err   <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_en     <= w_en_nxt;
            r_op_err <= w_err_nxt;
            if (w_en_nxt) begin
                r_sel <= w_sel_nxt;
                r_x   <= sw;
            end
            if (w_cnt_inc) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign en       = r_en;
    assign sel      = r_sel;
    assign x        = r_x;
    assign op_err   = r_op_err;
    assign op_count = r_op_count;
    assign stage    = r_state;
    assign ready    = (r_state == DONE);

endmodule
